// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the common data bus. Every execution unit owns a
// one-entry holding buffer. One buffered result per cycle is granted, with
// priority rotating past the last winner, and copied into a registered
// broadcast stage. The ROB, reservation station, LSB and dispatcher therefore
// all see a single writer.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous reset, active high, dominates clear and rdy_in
//   rdy_in        global ready; low freezes every register
//   clear         misprediction flush; empties all buffers
//   req_valid     per requester: result presented
//   req_ready     per requester: result accepted this cycle
//   req_rob_id    packed ROB ids, slice i = [i*ROB_W +: ROB_W]
//   req_val       packed 32-bit result values
//   req_is_jump   per requester: taken branch / jump
//   req_jump_pc   packed 32-bit branch targets
//   cdb_en        broadcast valid (one cycle per granted entry)
//   cdb_rob_id    broadcast ROB id
//   cdb_val       broadcast value
//   cdb_is_jump   broadcast is-jump flag
//   cdb_jump_pc   broadcast target
//   cdb_src       one-hot source of the broadcast, meaningful while cdb_en = 1
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NREQ  = 3,
    parameter int ROB_W = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ROB_W-1:0] req_rob_id,
    input  logic [NREQ*32-1:0]    req_val,
    input  logic [NREQ-1:0]       req_is_jump,
    input  logic [NREQ*32-1:0]    req_jump_pc,
    output logic                  cdb_en,
    output logic [ROB_W-1:0]      cdb_rob_id,
    output logic [31:0]           cdb_val,
    output logic                  cdb_is_jump,
    output logic [31:0]           cdb_jump_pc,
    output logic [NREQ-1:0]       cdb_src
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    // Holding buffers
    logic [NREQ-1:0]  hv;
    logic [ROB_W-1:0] buf_rob   [NREQ];
    logic [31:0]      buf_val   [NREQ];
    logic             buf_jump  [NREQ];
    logic [31:0]      buf_pc    [NREQ];

    logic [PTR_W-1:0] rr_ptr;

    // Grant
    logic [2*NREQ-1:0] hv_rot;
    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [PTR_W:0]    idx_sum;

    // Selected payload
    logic [ROB_W-1:0]  sel_rob;
    logic [31:0]       sel_val;
    logic              sel_jump;
    logic [31:0]       sel_pc;

    logic              accept_ok;
    logic [PTR_W-1:0]  rr_next;

    // Rotating the doubled hv vector right by rr_ptr puts the highest-priority
    // candidate at bit 0, so the scan below uses only constant bit positions.
    always_comb begin
        hv_rot  = {hv, hv} >> rr_ptr;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && hv_rot[k]) begin
                gnt_any = 1'b1;
                idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (idx_sum >= (PTR_W+1)'(NREQ)) begin
                    idx_sum = idx_sum - (PTR_W+1)'(NREQ);
                end
                gnt_idx = idx_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = gnt_any && (gnt_idx == PTR_W'(i));
        end
    end

    always_comb begin
        sel_rob  = '0;
        sel_val  = '0;
        sel_jump = 1'b0;
        sel_pc   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_rob  = buf_rob[i];
                sel_val  = buf_val[i];
                sel_jump = buf_jump[i];
                sel_pc   = buf_pc[i];
            end
        end
    end

    assign rr_next = (gnt_idx == LAST_IDX) ? '0 : PTR_W'(gnt_idx + 1'b1);

    // A buffer can take a new result when empty, or when its current content is
    // leaving on the bus this very cycle (back-to-back streaming).
    assign accept_ok = rdy_in & ~clear & ~rst_in;
    assign req_ready = {NREQ{accept_ok}} & (~hv | gnt);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hv          <= '0;
            rr_ptr      <= '0;
            cdb_en      <= 1'b0;
            cdb_rob_id  <= '0;
            cdb_val     <= '0;
            cdb_is_jump <= 1'b0;
            cdb_jump_pc <= '0;
            cdb_src     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_rob[i]  <= '0;
                buf_val[i]  <= '0;
                buf_jump[i] <= 1'b0;
                buf_pc[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                // Flush drops buffered and incoming results; the rotation
                // point is kept so fairness continues across the flush.
                hv     <= '0;
                cdb_en <= 1'b0;
            end else begin
                if (gnt_any) begin
                    cdb_en      <= 1'b1;
                    cdb_rob_id  <= sel_rob;
                    cdb_val     <= sel_val;
                    cdb_is_jump <= sel_jump;
                    cdb_jump_pc <= sel_pc;
                    cdb_src     <= gnt;
                    rr_ptr      <= rr_next;
                end else begin
                    cdb_en <= 1'b0;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        // Reload wins over the grant-driven clear.
                        hv[i]       <= 1'b1;
                        buf_rob[i]  <= req_rob_id[i*ROB_W +: ROB_W];
                        buf_val[i]  <= req_val[i*32 +: 32];
                        buf_jump[i] <= req_is_jump[i];
                        buf_pc[i]   <= req_jump_pc[i*32 +: 32];
                    end else if (gnt[i]) begin
                        hv[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int RW = 4;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, clear;
    logic [N-1:0]    req_valid, req_ready, req_is_jump;
    logic [N*RW-1:0] req_rob_id;
    logic [N*32-1:0] req_val, req_jump_pc;
    logic            cdb_en, cdb_is_jump;
    logic [RW-1:0]   cdb_rob_id;
    logic [31:0]     cdb_val, cdb_jump_pc;
    logic [N-1:0]    cdb_src;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.NREQ(N), .ROB_W(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_id(req_rob_id), .req_val(req_val),
        .req_is_jump(req_is_jump), .req_jump_pc(req_jump_pc),
        .cdb_en(cdb_en), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .cdb_is_jump(cdb_is_jump), .cdb_jump_pc(cdb_jump_pc), .cdb_src(cdb_src)
    );

    // Behavioural model: per-requester slot contents plus broadcast registers.
    bit            m_hv   [N];
    logic [RW-1:0] m_rob  [N];
    logic [31:0]   m_val  [N];
    logic          m_jmp  [N];
    logic [31:0]   m_pc   [N];
    int            m_rr;
    logic          m_en;
    logic [RW-1:0] m_crob;
    logic [31:0]   m_cval;
    logic          m_cjmp;
    logic [31:0]   m_cpc;
    logic [N-1:0]  m_src;

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (m_hv[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // One clock: check req_ready, advance model at the edge, check outputs.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = m_grant();
        for (int i = 0; i < N; i++)
            exp_rdy[i] = !rst_in && rdy_in && !clear && (!m_hv[i] || g == i);
        chk("req_ready", req_ready, exp_rdy);
        last_ready = req_ready;
        @(posedge clk_in);
        if (rst_in) begin
            for (int i = 0; i < N; i++) m_hv[i] = 0;
            m_rr = 0; m_en = 0; m_crob = 0; m_cval = 0; m_cjmp = 0; m_cpc = 0; m_src = 0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < N; i++) m_hv[i] = 0;
                m_en = 0;
            end else begin
                if (g >= 0) begin
                    m_en = 1; m_crob = m_rob[g]; m_cval = m_val[g];
                    m_cjmp = m_jmp[g]; m_cpc = m_pc[g];
                    m_src = N'(1) << g;
                    m_hv[g] = 0;
                    m_rr = (g + 1) % N;
                end else begin
                    m_en = 0;
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && exp_rdy[i]) begin
                        m_hv[i] = 1;
                        m_rob[i] = req_rob_id[i*RW +: RW];
                        m_val[i] = req_val[i*32 +: 32];
                        m_jmp[i] = req_is_jump[i];
                        m_pc[i]  = req_jump_pc[i*32 +: 32];
                    end
                end
            end
        end
        @(negedge clk_in);
        chk("cdb_en", cdb_en, m_en);
        chk("cdb_rob_id", cdb_rob_id, m_crob);
        chk("cdb_val", cdb_val, m_cval);
        chk("cdb_is_jump", cdb_is_jump, m_cjmp);
        chk("cdb_jump_pc", cdb_jump_pc, m_cpc);
        if (m_en) chk("cdb_src", cdb_src, m_src);
    endtask

    task automatic set_req(input int i, input bit v, input logic [RW-1:0] rob,
                           input logic [31:0] val, input bit j, input logic [31:0] pc);
        req_valid[i]            = v;
        req_rob_id[i*RW +: RW]  = rob;
        req_val[i*32 +: 32]     = val;
        req_is_jump[i]          = j;
        req_jump_pc[i*32 +: 32] = pc;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_rob_id = '0; req_val = '0; req_is_jump = '0; req_jump_pc = '0;
        clear = 0; rdy_in = 1; rst_in = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1;
        cycle();
        cycle();
        rst_in = 0;
    endtask

    task automatic load_three(input logic [RW-1:0] r0, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
        set_req(0, 1, r0, 32'h100 + r0, 0, 0);
        set_req(1, 1, r1, 32'h100 + r1, 1, 32'h8000_0000 + r1);
        set_req(2, 1, r2, 32'h100 + r2, 0, 0);
        cycle();
        req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    bit            pend [N];
    int            alu_next, lsb_t, lsb_b;
    bit            lsb_acc;

    initial begin
        @(negedge clk_in);
        do_reset();
        chk("rst_en", cdb_en, 0);
        chk("rst_rob", cdb_rob_id, 0);
        chk("rst_src", cdb_src, 0);

        // Single request
        set_req(0, 1, 5, 32'h1234, 0, 0);
        #1 chk("t1_ready0", req_ready[0], 1);
        cycle();
        req_valid = '0;
        chk("t1_en_k", cdb_en, 0);
        cycle();
        chk("t1_en", cdb_en, 1);
        chk("t1_rob", cdb_rob_id, 5);
        chk("t1_val", cdb_val, 32'h1234);
        chk("t1_src", cdb_src, 3'b001);
        cycle();
        chk("t1_en_off", cdb_en, 0);

        // Contention from rr_ptr = 0
        do_reset();
        load_three(1, 2, 3);
        cycle(); chk("t2_a", {cdb_en, cdb_rob_id, cdb_src}, {1'b1, 4'd1, 3'b001});
        cycle(); chk("t2_b", {cdb_en, cdb_rob_id, cdb_src}, {1'b1, 4'd2, 3'b010});
        cycle(); chk("t2_c", {cdb_en, cdb_rob_id, cdb_src}, {1'b1, 4'd3, 3'b100});
        chk("t2_rr", dut.rr_ptr, 0);
        cycle(); chk("t2_idle", cdb_en, 0);

        // Backpressure: ALU streams 1..4, LSB holds rob 9
        do_reset();
        alu_next = 1; lsb_acc = 0; lsb_t = -1; lsb_b = -1;
        for (int c = 0; c < 12; c++) begin
            set_req(0, alu_next <= 4, RW'(alu_next), 32'(alu_next), 0, 0);
            set_req(1, !lsb_acc, 9, 32'h99, 0, 0);
            cycle();
            if (last_ready[0] && req_valid[0]) alu_next++;
            if (last_ready[1] && req_valid[1]) begin lsb_acc = 1; lsb_t = c; end
            if (cdb_en && cdb_src == 3'b010 && lsb_b < 0) lsb_b = c;
        end
        chk("t3_lsb_seen", lsb_b >= 0, 1);
        chk("t3_lsb_latency", (lsb_b - lsb_t) <= 3, 1);
        chk("t3_alu_done", alu_next, 5);
        req_valid = '0;

        // Flush
        do_reset();
        set_req(0, 1, 1, 1, 0, 0); set_req(1, 1, 2, 2, 0, 0);
        cycle();
        req_valid = '0;
        clear = 1;
        set_req(2, 1, 7, 7, 0, 0);
        cycle();
        clear = 0; req_valid = '0;
        chk("t4_en_clear", cdb_en, 0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t4_quiet", cdb_en, 0);
        end
        chk("t4_rr", dut.rr_ptr, 0);
        set_req(2, 1, 6, 32'h66, 0, 0);
        cycle();
        req_valid = '0;
        cycle();
        chk("t4_new", {cdb_en, cdb_rob_id, cdb_src}, {1'b1, 4'd6, 3'b100});

        // Freeze
        do_reset();
        load_three(1, 2, 3);
        cycle();
        chk("t5_pre", {cdb_en, cdb_rob_id}, {1'b1, 4'd1});
        rdy_in = 0;
        for (int c = 0; c < 3; c++) begin
            clear = (c == 1);
            set_req(0, 1, 12, 12, 0, 0);
            #1 chk("t5_ready", req_ready, 0);
            cycle();
            chk("t5_hold", {cdb_en, cdb_rob_id}, {1'b1, 4'd1});
        end
        clear = 0; req_valid = '0; rdy_in = 1;
        cycle(); chk("t5_r2", {cdb_en, cdb_rob_id}, {1'b1, 4'd2});
        cycle(); chk("t5_r3", {cdb_en, cdb_rob_id}, {1'b1, 4'd3});

        // Reset mid-traffic
        do_reset();
        load_three(1, 2, 3);
        cycle(); cycle();
        chk("t6_pre", cdb_en, 1);
        rst_in = 1; rdy_in = 0; clear = 1;
        cycle();
        rst_in = 0; rdy_in = 1; clear = 0;
        chk("t6_zero", {cdb_en, cdb_rob_id, cdb_val, cdb_is_jump, cdb_jump_pc, cdb_src}, '0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t6_lost", cdb_en, 0);
        end
        load_three(4, 5, 6);
        cycle();
        chk("t6_first", {cdb_en, cdb_rob_id, cdb_src}, {1'b1, 4'd4, 3'b001});

        // Random traffic
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 55)) begin
                    pend[i] = 1;
                    set_req(i, 1, RW'($urandom), $urandom, 1'($urandom), $urandom);
                end else if (!pend[i]) begin
                    req_valid[i] = 0;
                end
            end
            rdy_in = ($urandom_range(0, 99) >= 15);
            clear  = ($urandom_range(0, 99) < 4);
            rst_in = ($urandom_range(0, 199) < 2);
            cycle();
            for (int i = 0; i < N; i++)
                if (req_valid[i] && last_ready[i]) pend[i] = 0;
        end
        idle_inputs();
        for (int c = 0; c < 5; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB) of the out-of-order RISC-V core. The ALU, the load/store buffer and any later execution unit each produce a result tagged with a ROB id. Those results must be broadcast on one shared bus to the ROB, the reservation station, the LSB and the dispatcher. The block buffers one result per requester, grants one buffered result per cycle with rotating priority, and drives a single registered CDB, so the consumers see exactly one writer.

## Interface
- `NREQ`, default 3: number of requesters. Index 0 = ALU, 1 = LSB, 2 = spare.
- `ROB_W`, default 4: ROB id width.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous reset, active-high.
- `rdy_in` input 1: global ready. Low freezes all state.
- `clear` input 1: misprediction flush from the ROB.
- `req_valid` input NREQ: requester i presents a result.
- `req_ready` output NREQ: requester i's result is accepted this cycle.
- `req_rob_id` input NREQ*ROB_W: packed ROB ids. Slice i is `[i*ROB_W +: ROB_W]`.
- `req_val` input NREQ*32: packed result values.
- `req_is_jump` input NREQ: result is a taken branch or jump.
- `req_jump_pc` input NREQ*32: packed branch target.
- `cdb_en` output 1: broadcast valid.
- `cdb_rob_id` output ROB_W: broadcast ROB id.
- `cdb_val` output 32: broadcast value.
- `cdb_is_jump` output 1: broadcast is-jump flag.
- `cdb_jump_pc` output 32: broadcast target.
- `cdb_src` output NREQ: one-hot source of the current broadcast.

## Operation
- Each requester has a one-entry holding buffer holding `hv[i]`, rob_id, val, is_jump and jump_pc.
- Acceptance:
  - `req_ready[i] = rdy_in & ~clear & (~hv[i] | gnt[i])`.
  - On `req_valid[i] & req_ready[i]` the buffer loads and `hv[i]` is set.
  - The buffer's own grant and a new load may coincide in one cycle; the load wins.
- Grant (combinational from registered state):
  - Scan `hv` starting at index `rr_ptr`, upward modulo NREQ.
  - The first set bit is granted; `gnt` is one-hot or zero.
- On a grant to index g:
  - The output registers load buffer g and `cdb_en` goes to 1.
  - `hv[g]` clears unless it is reloaded the same cycle.
  - `rr_ptr` becomes (g+1) mod NREQ.
- With no grant, `cdb_en` goes to 0 and the other output registers hold.
- Starvation bound: a buffered entry is broadcast within NREQ cycles of entering its buffer.
- Clear, when `rdy_in` = 1:
  - Every `hv` goes to 0 and `cdb_en` goes to 0 at the next edge.
  - `req_valid` during clear is dropped.
  - `rr_ptr` is unchanged.
- `rdy_in` = 0:
  - No state changes, including `clear`, which is ignored that cycle.
  - `req_ready` is 0.
  - All outputs hold their values.
- Reset: `rst_in` dominates `clear` and `rdy_in`.
  - `hv` = 0 and `rr_ptr` = 0.
  - `cdb_en` = 0 and `cdb_src` = 0.
  - `cdb_rob_id` = 0, `cdb_val` = 0, `cdb_is_jump` = 0, `cdb_jump_pc` = 0.
  - `req_ready` is 0 during the reset cycle.

## Timing
- Latency from an accepted request to `cdb_en` is 2 cycles minimum:
  - The request is accepted at edge k (buffer loaded).
  - The grant is evaluated in cycle k and registered at edge k+1.
  - `cdb_en` is high during cycle k+1, i.e. the second cycle counting the request cycle.
- Throughput: one broadcast per cycle overall. Each requester can sustain one result per cycle while it is granted every cycle.
- `cdb_en` is asserted for exactly one cycle per granted entry. Consumers sample it on `rdy_in` & `cdb_en`.
- A requester that holds `req_valid` without `req_ready` keeps its payload stable until accepted.
- `cdb_src` is valid only while `cdb_en` = 1.

## Test plan
- Single request: reset, then ALU presents rob 5, val 0x1234 for 1 cycle. Required:
  - `req_ready[0]` = 1.
  - Two cycles later `cdb_en` = 1 for one cycle, with rob 5, val 0x1234, `cdb_src` = 001.
- Contention: all three requesters present (rob 1, 2, 3) in the same cycle with `rr_ptr` = 0. Required:
  - Broadcasts on 3 consecutive cycles in order 1, 2, 3.
  - `rr_ptr` ends at 0.
- Backpressure: ALU streams rob 1..4 back-to-back while the LSB holds rob 9. Required:
  - Grants interleave with the LSB and the LSB is broadcast within 3 cycles.
  - `req_ready[0]` drops only while buffer 0 is full and not granted.
- Flush: two entries are buffered and `clear` pulses. Required:
  - No `cdb_en` after the clear edge.
  - A `req_valid` presented during clear is never broadcast.
  - A new request right after clear broadcasts normally.
- Freeze: `rdy_in` goes low for 3 cycles with entries pending. Required:
  - Outputs and `hv` hold and `req_ready` = 0.
  - Broadcast order resumes unchanged once `rdy_in` returns high.
- Reset mid-traffic: assert `rst_in` with `cdb_en` = 1. Required:
  - All outputs are 0 next cycle and pending entries are lost.
  - `rr_ptr` = 0, checked by a 3-way contention test that grants index 0 first.
